cfg_sync_fifo: RTL

CFG_SYNC_FIFO -- requirements
Module: cfg_sync_fifo

---
 rtl/cfg_sync_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cfg_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sync_fifo
// Function : single-clock FIFO with registered read port, configurable
//            almost-full/almost-empty thresholds, flush and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = (2**ADDR_WIDTH) - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  W_INC,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  R_INC,
   input  logic                  FLUSH,
   input  logic                  ERR_CLR,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic [ADDR_WIDTH:0]   FILL_LEVEL,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int unsigned         c_depth     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_depth_lvl = c_depth[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_af_lvl    = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_ae_lvl    = AE_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_ptr_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] c_ptr_zero  = '0;

   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_fill;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_af;
   logic                  r_ae;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_ovf_set;
   logic                  w_unf_set;
   logic [ADDR_WIDTH:0]   w_wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_rd_ptr_nxt;
   logic [ADDR_WIDTH:0]   w_fill_nxt;

   // A write into a full FIFO is legal only when a read frees a slot this cycle.
   assign w_rd_acc  = R_INC && !r_empty && !FLUSH;
   assign w_wr_acc  = W_INC && (!r_full || w_rd_acc) && !FLUSH;
   assign w_ovf_set = W_INC && r_full && !w_rd_acc && !FLUSH;
   assign w_unf_set = R_INC && r_empty && !FLUSH;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (FLUSH) begin
         w_wr_ptr_nxt = c_ptr_zero;
         w_rd_ptr_nxt = c_ptr_zero;
      end else begin
         if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
         if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
      end
      // Wrap bits make the pointer difference span 0..DEPTH unambiguously.
      w_fill_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
   end

   always_ff @(posedge CLK) begin
      if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_af       <= (c_af_lvl == c_ptr_zero);
         r_ae       <= 1'b1;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_fill     <= w_fill_nxt;
         r_full     <= (w_fill_nxt == c_depth_lvl);
         r_empty    <= (w_fill_nxt == c_ptr_zero);
         r_af       <= (w_fill_nxt >= c_af_lvl);
         r_ae       <= (w_fill_nxt <= c_ae_lvl);
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

         if (w_ovf_set)    r_ovf <= 1'b1;
         else if (ERR_CLR) r_ovf <= 1'b0;

         if (w_unf_set)    r_unf <= 1'b1;
         else if (ERR_CLR) r_unf <= 1'b0;
      end
   end

   assign RD_DATA      = r_rd_data;
   assign RD_VALID     = r_rd_valid;
   assign FULL         = r_full;
   assign EMPTY        = r_empty;
   assign ALMOST_FULL  = r_af;
   assign ALMOST_EMPTY = r_ae;
   assign FILL_LEVEL   = r_fill;
   assign OVERFLOW     = r_ovf;
   assign UNDERFLOW    = r_unf;

endmodule
`default_nettype wire
